// File: rtl/vga_sprite_render.sv
// vga_sprite_render: pixel-colour stage that draws one ROM-backed sprite over a flat background
//
// Ports:
//   CLK, RESET_N            pixel clock, asynchronous active-low reset
//   hc, vc, is_blanking     raster position and blanking from the timing generator
//   hsync_in, vsync_in      active-low syncs aligned with hc/vc
//   obj_x, obj_y, obj_en    sprite position/enable, sampled once per frame
//   spr_addr, spr_data      synchronous texel ROM (1-cycle latency), {row,col} addressing
//   red, green, blue        12-bit pixel colour, 3 cycles behind hc/vc
//   hsync_out, vsync_out    syncs delayed to match the colour pipeline
//   frame_tick, frame_count pulse and wrapping count of sprite-position loads
module vga_sprite_render #(
    parameter int          SPR_W       = 16,
    parameter int          SPR_H       = 16,
    parameter logic [11:0] BG_COLOR    = 12'h008,
    parameter logic [11:0] TRANSPARENT = 12'hF0F,
    parameter int          H_VISIBLE   = 640,
    parameter int          V_VISIBLE   = 480
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        is_blanking,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  obj_x,
    input  logic [9:0]  obj_y,
    input  logic        obj_en,
    output logic [7:0]  spr_addr,
    input  logic [11:0] spr_data,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_tick,
    output logic [7:0]  frame_count
);
    logic [9:0]  x_s, y_s;
    logic        en_s;
    logic [10:0] dx, dy;
    logic        load, hit;
    logic        blank1, blank2, hit1, hit2;
    logic [2:0]  hs_d, vs_d;
    logic [11:0] rgb;

    // Position is latched in the first blanked line so a whole frame uses one position.
    assign load = hc == 10'd0 && {1'b0, vc} == 11'(V_VISIBLE);
    // 11-bit differences: hc < x_s never wraps into a small positive offset.
    assign dx   = {1'b0, hc} - {1'b0, x_s};
    assign dy   = {1'b0, vc} - {1'b0, y_s};
    assign hit  = en_s && !is_blanking
                  && hc >= x_s && dx < 11'(SPR_W) && {1'b0, hc} < 11'(H_VISIBLE)
                  && vc >= y_s && dy < 11'(SPR_H) && {1'b0, vc} < 11'(V_VISIBLE);

    assign {red, green, blue} = rgb;
    assign hsync_out = hs_d[2];
    assign vsync_out = vs_d[2];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x_s         <= '0;
            y_s         <= '0;
            en_s        <= 1'b0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
            spr_addr    <= '0;
            blank1      <= 1'b0;
            blank2      <= 1'b0;
            hit1        <= 1'b0;
            hit2        <= 1'b0;
            hs_d        <= 3'b111;
            vs_d        <= 3'b111;
            rgb         <= '0;
        end else begin
            if (load) begin
                x_s  <= obj_x;
                y_s  <= obj_y;
                en_s <= obj_en;
            end
            frame_tick  <= load;
            frame_count <= frame_count + {7'd0, load};
            // Offsets are below SPR_W/SPR_H on a hit, so their upper bits are already zero.
            if (hit)
                spr_addr <= {dy[3:0], dx[3:0]};
            blank1 <= is_blanking;
            hit1   <= hit;
            blank2 <= blank1;
            hit2   <= hit1;
            hs_d   <= {hs_d[1:0], hsync_in};
            vs_d   <= {vs_d[1:0], vsync_in};
            rgb    <= blank2 ? 12'h000 : (hit2 && spr_data != TRANSPARENT) ? spr_data : BG_COLOR;
        end
    end
endmodule

// File: tb/tb_vga_sprite_render.sv
// tb_vga_sprite_render: scoreboard bench for vga_sprite_render with a behavioural ROM and pixel model
module tb_vga_sprite_render;
    logic        CLK = 1'b0, RESET_N = 1'b0;
    logic [9:0]  hc = '0, vc = '0, obj_x = '0, obj_y = '0;
    logic        is_blanking = 1'b1, hsync_in = 1'b1, vsync_in = 1'b1, obj_en = 1'b0;
    logic [7:0]  spr_addr, frame_count;
    logic [11:0] spr_data;
    logic [3:0]  red, green, blue;
    logic        hsync_out, vsync_out, frame_tick;

    logic [11:0] rom [256];
    int          cyc = 0, n_tests = 0, n_fail = 0;

    typedef struct {int due; logic [7:0] addr; logic tick; logic [7:0] fc;} s1_t;
    typedef struct {int due; logic [11:0] rgb; logic hs; logic vs;} s3_t;
    s1_t q1[$];
    s3_t q3[$];

    logic [9:0] mx = '0, my = '0;
    logic       men = 1'b0;
    logic [7:0] maddr = '0, mfc = '0;

    vga_sprite_render dut (
        .CLK(CLK), .RESET_N(RESET_N), .hc(hc), .vc(vc), .is_blanking(is_blanking),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en),
        .spr_addr(spr_addr), .spr_data(spr_data), .red(red), .green(green), .blue(blue),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_tick(frame_tick), .frame_count(frame_count)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;
    always @(posedge CLK) spr_data <= rom[spr_addr];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET_N) begin
            while (q1.size() != 0 && q1[0].due == cyc) begin
                s1_t e;
                e = q1.pop_front();
                check("spr_addr", 16'(spr_addr), 16'(e.addr));
                check("frame_tick", 16'(frame_tick), 16'(e.tick));
                check("frame_count", 16'(frame_count), 16'(e.fc));
            end
            while (q3.size() != 0 && q3[0].due == cyc) begin
                s3_t e;
                e = q3.pop_front();
                check("rgb", 16'({red, green, blue}), 16'(e.rgb));
                check("sync", 16'({hsync_out, vsync_out}), 16'({e.hs, e.vs}));
            end
        end
    end

    // Apply one raster position for one cycle and queue what the DUT must produce for it.
    task automatic drive(input logic [9:0] h, input logic [9:0] v);
        logic [10:0] dx, dy;
        logic        blank, hit, ld;
        logic [11:0] d;
        s1_t         a;
        s3_t         b;
        @(negedge CLK);
        blank       = h >= 10'd640 || v >= 10'd480;
        ld          = h == 10'd0 && v == 10'd480;
        hc          = h;
        vc          = v;
        is_blanking = blank;
        hsync_in    = !(h >= 10'd656 && h <= 10'd751);
        vsync_in    = !(v == 10'd490 || v == 10'd491);
        dx  = {1'b0, h} - {1'b0, mx};
        dy  = {1'b0, v} - {1'b0, my};
        hit = men && !blank && h >= mx && dx < 11'd16 && v >= my && dy < 11'd16;
        if (hit)
            maddr = {dy[3:0], dx[3:0]};
        if (ld) begin
            mx  = obj_x;
            my  = obj_y;
            men = obj_en;
            mfc = mfc + 8'd1;
        end
        a.due = cyc + 1; a.addr = maddr; a.tick = ld; a.fc = mfc;
        q1.push_back(a);
        d = rom[maddr];
        b.due = cyc + 3;
        b.rgb = blank ? 12'h000 : (hit && d != 12'hF0F) ? d : 12'h008;
        b.hs  = hsync_in;
        b.vs  = vsync_in;
        q3.push_back(b);
    endtask

    task automatic line(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++)
            drive(10'(h), 10'(v));
    endtask

    task automatic load(input int x, input int y, input logic en);
        obj_x  = 10'(x);
        obj_y  = 10'(y);
        obj_en = en;
        drive(10'd0, 10'd480);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = 12'hA53;
        rom[8'h11] = 12'hF0F;
        repeat (2) @(negedge CLK);
        check("rst_rgb", 16'({red, green, blue}), 16'h000);
        check("rst_sync", 16'({hsync_out, vsync_out}), 16'h0003);
        check("rst_addr", 16'(spr_addr), 16'h0000);
        check("rst_tick", 16'(frame_tick), 16'h0000);
        check("rst_fc", 16'(frame_count), 16'h0000);
        RESET_N = 1'b1;
        // sprite hit, ROM addressing, transparency
        load(100, 50, 1'b1);
        line(50, 96, 120);
        line(51, 96, 120);
        line(65, 96, 120);
        line(66, 96, 120);
        // disabled sprite shows only background
        load(100, 50, 1'b0);
        line(50, 96, 120);
        line(300, 0, 10);
        // sync alignment through horizontal and vertical sync regions
        line(100, 640, 799);
        line(489, 790, 799);
        line(490, 0, 5);
        line(491, 0, 3);
        line(492, 0, 3);
        // position changes mid-frame wait for the next load
        load(100, 50, 1'b1);
        line(60, 95, 125);
        obj_x = 10'd300;
        line(60, 95, 125);
        line(60, 295, 320);
        drive(10'd0, 10'd480);
        line(60, 95, 125);
        line(60, 295, 320);
        // asynchronous reset in the middle of a sprite line
        line(60, 300, 303);
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_rgb", 16'({red, green, blue}), 16'h000);
        check("mid_rst_sync", 16'({hsync_out, vsync_out}), 16'h0003);
        check("mid_rst_fc", 16'(frame_count), 16'h0000);
        check("mid_rst_tick", 16'(frame_tick), 16'h0000);
        check("mid_rst_addr", 16'(spr_addr), 16'h0000);
        q1.delete();
        q3.delete();
        mx = '0; my = '0; men = 1'b0; maddr = '0; mfc = '0;
        @(negedge CLK);
        RESET_N = 1'b1;
        line(60, 295, 320);
        drive(10'd0, 10'd480);
        line(60, 295, 320);
        // clipping at the right/bottom edges, no wrap to column/line 0
        load(632, 472, 1'b1);
        line(472, 620, 639);
        line(472, 0, 8);
        line(479, 630, 639);
        line(0, 630, 639);
        line(7, 0, 8);
        line(0, 0, 8);
        load(700, 50, 1'b1);
        line(50, 0, 20);
        line(50, 630, 639);
        load(100, 500, 1'b1);
        line(50, 95, 120);
        line(479, 95, 120);
        // frame counter wraps 255 -> 0
        while (mfc != 8'hFF) begin
            drive(10'd0, 10'd480);
            drive(10'd700, 10'd500);
        end
        drive(10'd0, 10'd480);
        repeat (4) drive(10'd700, 10'd500);
        repeat (4) @(negedge CLK);
        #1;
        check("drain", 16'(q1.size() + q3.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
